// File: rtl/mcu_job_sequencer.sv
// mcu_job_sequencer
// Buffers MCU job descriptors (data/grid/scale sizes plus a job tag) in a small
// queue and runs them one at a time on the Memory Control Unit wrapper. Each
// job produces exactly one status word (OK, MCU error, watchdog timeout, or
// empty job). Single clock domain (fsm_clk), asynchronous active-high reset.
module mcu_job_sequencer #(
  parameter int ADDR_WIDTH_DATA  = 32,
  parameter int ADDR_WIDTH_GRID  = 32,
  parameter int ADDR_WIDTH_SCALE = 32,
  parameter int JOB_ID_WIDTH     = 8,
  parameter int JOB_FIFO_DEPTH   = 4,
  parameter int TIMEOUT_CYCLES   = 65535,
  parameter int TIMEOUT_WIDTH    = 16
) (
  input  logic                      fsm_clk,
  input  logic                      rst,
  // Descriptor intake
  input  logic                      s_job_valid,
  output logic                      s_job_ready,
  input  logic [ADDR_WIDTH_DATA:0]  s_job_data_size,
  input  logic [ADDR_WIDTH_GRID:0]  s_job_grid_size,
  input  logic [ADDR_WIDTH_SCALE:0] s_job_scle_size,
  input  logic [JOB_ID_WIDTH-1:0]   s_job_id,
  input  logic                      flush,
  // Status output
  output logic                      m_sts_valid,
  input  logic                      m_sts_ready,
  output logic [JOB_ID_WIDTH-1:0]   m_sts_id,
  output logic [1:0]                m_sts_code,
  // MCU wrapper side
  output logic                      mcu_operation_start,
  output logic [ADDR_WIDTH_DATA:0]  mcu_data_size,
  output logic [ADDR_WIDTH_GRID:0]  mcu_grid_size,
  output logic [ADDR_WIDTH_SCALE:0] mcu_scle_size,
  input  logic                      mcu_operation_busy,
  input  logic                      mcu_operation_complete,
  input  logic                      mcu_operation_error,
  // Observability
  output logic                      seq_busy,
  output logic [31:0]               jobs_done
);

  localparam int DW    = ADDR_WIDTH_DATA + 1;
  localparam int GW    = ADDR_WIDTH_GRID + 1;
  localparam int SW    = ADDR_WIDTH_SCALE + 1;
  localparam int PTR_W = (JOB_FIFO_DEPTH > 1) ? $clog2(JOB_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(JOB_FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(JOB_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Watchdog arithmetic is done one bit wider so the limit compare never wraps.
  localparam logic [TIMEOUT_WIDTH:0] WD_LIMIT  = (TIMEOUT_WIDTH + 1)'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH:0] WD_ONE    = (TIMEOUT_WIDTH + 1)'(1);
  localparam bit                     WD_ENABLE = (TIMEOUT_CYCLES != 0);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_REPORT    = 3'd4;

  localparam logic [1:0] CODE_OK        = 2'd0;
  localparam logic [1:0] CODE_MCU_ERROR = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT   = 2'd2;
  localparam logic [1:0] CODE_EMPTY     = 2'd3;

  // ---------------------------------------------------------------------------
  // Descriptor queue
  // ---------------------------------------------------------------------------
  logic [DW-1:0]           fifo_data_q [JOB_FIFO_DEPTH];
  logic [GW-1:0]           fifo_grid_q [JOB_FIFO_DEPTH];
  logic [SW-1:0]           fifo_scle_q [JOB_FIFO_DEPTH];
  logic [JOB_ID_WIDTH-1:0] fifo_id_q   [JOB_FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;

  logic push;
  logic pop;
  logic fifo_empty;

  logic [DW-1:0]           head_data;
  logic [GW-1:0]           head_grid;
  logic [SW-1:0]           head_scle;
  logic [JOB_ID_WIDTH-1:0] head_id;

  // A flush drops whatever is being offered in the same cycle.
  assign push       = s_job_valid && ready_q && !flush;
  assign fifo_empty = (count_q == '0);

  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_grid = fifo_grid_q[rd_ptr_q];
  assign head_scle = fifo_scle_q[rd_ptr_q];
  assign head_id   = fifo_id_q[rd_ptr_q];

  // Descriptor storage holds payload only, so it carries no reset.
  always_ff @(posedge fsm_clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= s_job_data_size;
      fifo_grid_q[wr_ptr_q] <= s_job_grid_size;
      fifo_scle_q[wr_ptr_q] <= s_job_scle_size;
      fifo_id_q[wr_ptr_q]   <= s_job_id;
    end
  end

  // Queue pointers/occupancy; ready is registered from the next occupancy so it
  // sits low during reset and rises on the first clock afterwards.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
    ready_d = (count_d != CNT_FULL);
  end

  // Queue control registers.
  always_ff @(posedge fsm_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Job sequencing FSM
  // ---------------------------------------------------------------------------
  logic [2:0]               state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic [1:0]               code_q, code_d;
  logic                     start_q, start_d;
  logic [31:0]              jobs_done_q, jobs_done_d;
  logic [DW-1:0]            data_q, data_d;
  logic [GW-1:0]            grid_q, grid_d;
  logic [SW-1:0]            scle_q, scle_d;
  logic [JOB_ID_WIDTH-1:0]  id_q, id_d;

  logic [TIMEOUT_WIDTH:0]   wd_ext;
  logic [TIMEOUT_WIDTH:0]   wd_inc;
  logic                     wd_expired;

  // Watchdog including the current cycle, saturating at the limit. The job
  // times out in the cycle this count reaches TIMEOUT_CYCLES, so status shows
  // up TIMEOUT_CYCLES+1 cycles after the start pulse.
  always_comb begin
    wd_ext = {1'b0, wd_q};
    if (wd_ext >= WD_LIMIT) begin
      wd_inc = WD_LIMIT;
    end else begin
      wd_inc = wd_ext + WD_ONE;
    end
    wd_expired = WD_ENABLE && (wd_inc == WD_LIMIT);
  end

  // Next-state logic. The start pulse is registered on the IDLE->LAUNCH
  // transition so it is high exactly during the LAUNCH cycle.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    code_d      = code_q;
    start_d     = 1'b0;
    jobs_done_d = jobs_done_q;
    data_d      = data_q;
    grid_d      = grid_q;
    scle_d      = scle_q;
    id_d        = id_q;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A same-cycle flush wins: the head is discarded, not launched.
        if (!fifo_empty && !flush) begin
          pop     = 1'b1;
          data_d  = head_data;
          grid_d  = head_grid;
          scle_d  = head_scle;
          id_d    = head_id;
          start_d = (head_data != '0);
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (data_q == '0) begin
          code_d  = CODE_EMPTY;
          state_d = ST_REPORT;
        end else begin
          wd_d    = '0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY, ST_RUN: begin
        wd_d = wd_inc[TIMEOUT_WIDTH-1:0];
        if (mcu_operation_error) begin
          code_d  = CODE_MCU_ERROR;
          state_d = ST_REPORT;
        end else if (mcu_operation_complete) begin
          code_d  = CODE_OK;
          state_d = ST_REPORT;
        end else if ((state_q == ST_WAIT_BUSY) && mcu_operation_busy) begin
          state_d = ST_RUN;
        end else if (wd_expired) begin
          code_d  = CODE_TIMEOUT;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (m_sts_ready) begin
          jobs_done_d = jobs_done_q + 32'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, job and status registers.
  always_ff @(posedge fsm_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      code_q      <= CODE_OK;
      start_q     <= 1'b0;
      jobs_done_q <= '0;
      data_q      <= '0;
      grid_q      <= '0;
      scle_q      <= '0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      code_q      <= code_d;
      start_q     <= start_d;
      jobs_done_q <= jobs_done_d;
      data_q      <= data_d;
      grid_q      <= grid_d;
      scle_q      <= scle_d;
      id_q        <= id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_job_ready         = ready_q;
  assign m_sts_valid         = (state_q == ST_REPORT);
  assign m_sts_id            = id_q;
  assign m_sts_code          = code_q;
  assign mcu_operation_start = start_q;
  assign mcu_data_size       = data_q;
  assign mcu_grid_size       = grid_q;
  assign mcu_scle_size       = scle_q;
  assign seq_busy            = (state_q != ST_IDLE) || !fifo_empty;
  assign jobs_done           = jobs_done_q;

endmodule
